// File: rtl/data_sram_responder_pkg.sv
// Shared constants and the confreg offset decode for the data SRAM responder.
// Offsets are compared on the full low 16 bits of the byte address.
package data_sram_responder_pkg;

  localparam logic [15:0] CONFREG_HI_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_SWITCH = 16'h0004;
  localparam logic [15:0] OFF_NUM    = 16'h0008;
  localparam logic [15:0] OFF_TIMER  = 16'h000C;
  localparam logic [15:0] OFF_SIMU   = 16'h0010;

  typedef enum logic [2:0] {
    SEL_LED,
    SEL_SWITCH,
    SEL_NUM,
    SEL_TIMER,
    SEL_SIMU,
    SEL_NONE
  } conf_sel_e;

  function automatic conf_sel_e decode_offset(input logic [15:0] off);
    case (off)
      OFF_LED:    return SEL_LED;
      OFF_SWITCH: return SEL_SWITCH;
      OFF_NUM:    return SEL_NUM;
      OFF_TIMER:  return SEL_TIMER;
      OFF_SIMU:   return SEL_SIMU;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_spram.sv
// Single-port word RAM: synchronous write, registered read that only updates on re.
// Contents are never reset; the read register holds between reads.
module data_spram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: RAM plus a small config-register block (LED, switches,
// digit display, free-running timer, simulation flag) with a one-cycle read path.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter logic [15:0] CONFREG_HI = CONFREG_HI_DEFAULT,
  parameter logic [31:0] SIMU_FLAG  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_ce,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  logic        is_conf;
  conf_sel_e   conf_sel;
  logic        conf_wr;
  logic        conf_rd;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] conf_rdata_next;
  logic [1:0]  unused_addr_lsb;

  logic [15:0] led_reg;
  logic [31:0] num_reg;
  logic [31:0] timer_reg;
  logic [31:0] conf_rdata_reg;
  logic        rd_ram_reg;

  assign unused_addr_lsb = data_sram_addr[1:0];

  // Requests are dropped entirely while resetn is low.
  assign is_conf  = (data_sram_addr[31:16] == CONFREG_HI);
  assign conf_sel = decode_offset(data_sram_addr[15:0]);
  assign conf_wr  = resetn && data_sram_ce && data_sram_we && is_conf;
  assign conf_rd  = resetn && data_sram_ce && !data_sram_we && is_conf;
  assign ram_we   = resetn && data_sram_ce && data_sram_we && !is_conf;
  assign ram_re   = resetn && data_sram_ce && !data_sram_we && !is_conf;

  data_spram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    conf_rdata_next = 32'h0000_0000;
    case (conf_sel)
      SEL_LED:    conf_rdata_next = {16'h0000, led_reg};
      SEL_SWITCH: conf_rdata_next = {16'h0000, switch_in};
      SEL_NUM:    conf_rdata_next = num_reg;
      SEL_TIMER:  conf_rdata_next = timer_reg;
      SEL_SIMU:   conf_rdata_next = SIMU_FLAG;
      default:    conf_rdata_next = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led_reg        <= 16'h0000;
      num_reg        <= 32'h0000_0000;
      timer_reg      <= 32'h0000_0000;
      conf_rdata_reg <= 32'h0000_0000;
      rd_ram_reg     <= 1'b0;
    end else begin
      if (conf_wr && conf_sel == SEL_TIMER) begin
        timer_reg <= data_sram_wdata;
      end else begin
        timer_reg <= timer_reg + 32'd1;
      end
      if (conf_wr && conf_sel == SEL_LED) begin
        led_reg <= data_sram_wdata[15:0];
      end
      if (conf_wr && conf_sel == SEL_NUM) begin
        num_reg <= data_sram_wdata;
      end
      // The source flag remembers where the last read came from so rdata holds.
      if (conf_rd) begin
        conf_rdata_reg <= conf_rdata_next;
        rd_ram_reg     <= 1'b0;
      end else if (ram_re) begin
        rd_ram_reg <= 1'b1;
      end
    end
  end

  assign data_sram_rdata = rd_ram_reg ? ram_rdata : conf_rdata_reg;
  assign led_out         = led_reg;
  assign num_out         = num_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed testbench for data_sram_responder: RAM read/write, wrap, confreg, timer, reset.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  int n_cmp;
  int n_bad;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_ce    (ce),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the following rising edge is the request edge.
  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce    = c;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    n_cmp++;
    if (led_out !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want %h", led_out, 16'h0); end
    n_cmp++;
    if (num_out !== 32'h0) begin n_bad++; $display("FAIL reset_num: got %h want %h", num_out, 32'h0); end
    @(negedge clk);
    resetn = 1'b1;
    ce = 1'b1; we = 1'b0; addr = 32'hBFAF_000C;
    drive(1'b1, 1'b0, 32'hBFAF_000C, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_timer0: got %h want %h", rdata, 32'h0); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1) begin n_bad++; $display("FAIL timer_counts: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_ram_rw();
    drive(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_read: got %h want %h", rdata, 32'h1234_5678); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_hold_idle: got %h want %h", rdata, 32'h1234_5678); end
    drive(1'b1, 1'b1, 32'h0000_0044, 32'h1111_1111);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_hold_write: got %h want %h", rdata, 32'h1234_5678); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 32'h0000_4000, 32'hA5A5_A5A5);
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    n_cmp++;
    if (rdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL ram_wrap: got %h want %h", rdata, 32'hA5A5_A5A5); end
    drive(1'b1, 1'b0, 32'h0000_0003, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL ram_b2b: got %h want %h", rdata, 32'h1111_1111); end
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    n_cmp++;
    if (rdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL ram_lsb_ignored: got %h want %h", rdata, 32'hA5A5_A5A5); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_no_alias: got %h want %h", rdata, 32'h1234_5678); end
  endtask

  task automatic test_confreg();
    drive(1'b1, 1'b1, 32'hBFAF_0000, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 32'hBFAF_0008, 32'hCAFE_BABE);
    n_cmp++;
    if (led_out !== 16'hBEEF) begin n_bad++; $display("FAIL led_write: got %h want %h", led_out, 16'hBEEF); end
    drive(1'b1, 1'b0, 32'hBFAF_0000, 32'h0);
    n_cmp++;
    if (num_out !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL num_write: got %h want %h", num_out, 32'hCAFE_BABE); end
    drive(1'b1, 1'b0, 32'hBFAF_0008, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0000_BEEF) begin n_bad++; $display("FAIL led_read: got %h want %h", rdata, 32'h0000_BEEF); end
    drive(1'b1, 1'b0, 32'hBFAF_0020, 32'h0);
    n_cmp++;
    if (rdata !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL num_read: got %h want %h", rdata, 32'hCAFE_BABE); end
    drive(1'b1, 1'b1, 32'hBFAF_0020, 32'h7777_7777);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h want %h", rdata, 32'h0); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (led_out !== 16'hBEEF || num_out !== 32'hCAFE_BABE) begin
      n_bad++; $display("FAIL unmapped_write: got led %h num %h want led %h num %h", led_out, num_out, 16'hBEEF, 32'hCAFE_BABE);
    end
  endtask

  task automatic test_timer();
    drive(1'b1, 1'b1, 32'hBFAF_000C, 32'hFFFF_FFFE);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'hBFAF_000C, 32'h0);
    drive(1'b1, 1'b0, 32'hBFAF_000C, 32'h0);
    n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL timer_load: got %h want %h", rdata, 32'hFFFF_FFFF); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL timer_wrap: got %h want %h", rdata, 32'h0); end
  endtask

  task automatic test_switch_simu();
    switch_in = 16'h00F0;
    drive(1'b1, 1'b0, 32'hBFAF_0004, 32'h0);
    drive(1'b1, 1'b1, 32'hBFAF_0004, 32'h1234_5678);
    n_cmp++;
    if (rdata !== 32'h0000_00F0) begin n_bad++; $display("FAIL switch_read: got %h want %h", rdata, 32'h0000_00F0); end
    drive(1'b1, 1'b1, 32'hBFAF_0010, 32'h0000_0000);
    drive(1'b1, 1'b0, 32'hBFAF_0010, 32'h0);
    drive(1'b1, 1'b0, 32'hBFAF_0004, 32'h0);
    n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL simu_read: got %h want %h", rdata, 32'hFFFF_FFFF); end
    switch_in = 16'h0A05;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0000_0A05) begin n_bad++; $display("FAIL switch_ro: got %h want %h", rdata, 32'h0000_0A05); end
    n_cmp++;
    if (led_out !== 16'hBEEF || num_out !== 32'hCAFE_BABE) begin
      n_bad++; $display("FAIL ro_write_side_effect: got led %h num %h want led %h num %h", led_out, num_out, 16'hBEEF, 32'hCAFE_BABE);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    resetn = 1'b0;
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'hBAD0_BAD0;
    drive(1'b1, 1'b1, 32'hBFAF_000C, 32'h5555_5555);
    drive(1'b1, 1'b1, 32'hBFAF_0000, 32'h0000_1111);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want %h", rdata, 32'h0); end
    @(negedge clk);
    n_cmp++;
    if (led_out !== 16'h0 || num_out !== 32'h0) begin
      n_bad++; $display("FAIL rst_regs: got led %h num %h want led %h num %h", led_out, num_out, 16'h0, 32'h0);
    end
    resetn = 1'b1;
    ce = 1'b1; we = 1'b0; addr = 32'hBFAF_000C;
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_timer: got %h want %h", rdata, 32'h0); end
    drive(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    n_cmp++;
    if (rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rst_ram_kept: got %h want %h", rdata, 32'h1234_5678); end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (rdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL rst_ram_kept2: got %h want %h", rdata, 32'hA5A5_A5A5); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    ce = 1'b0;
    we = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    switch_in = 16'h0000;
    test_reset();
    test_ram_rw();
    test_wrap();
    test_confreg();
    test_timer();
    test_switch_simu();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
- REQ-001 SHALL provide parameter RAM_AW, default 12, meaning log2 of RAM depth in 32-bit words.
- REQ-002 SHALL provide parameter CONFREG_HI, default 16'hBFAF, meaning addr[31:16] value that selects the config-register region.
- REQ-003 SHALL provide parameter SIMU_FLAG, default 32'hFFFF_FFFF, meaning the constant returned by the SIMU register.
- REQ-004 clk  input  1  sole clock; all state changes on rising edge.
- REQ-005 resetn  input  1  synchronous reset, active-low.
- REQ-006 data_sram_ce  input  1  request valid for the current cycle.
- REQ-007 data_sram_we  input  1  1 = write, 0 = read; meaningful only when ce=1.
- REQ-008 data_sram_addr  input  32  byte address; addr[1:0] ignored.
- REQ-009 data_sram_wdata  input  32  write data, full word.
- REQ-010 data_sram_rdata  output  32  read data, registered.
- REQ-011 switch_in  input  16  board switch levels.
- REQ-012 led_out  output  16  LED register.
- REQ-013 num_out  output  32  digit-display register.

Function
- REQ-014 Decode: a request targets confreg when addr[31:16]==CONFREG_HI; otherwise it targets RAM.
- REQ-015 RAM index = addr[RAM_AW+1:2]; upper bits are truncated, so addresses wrap modulo the RAM depth.
- REQ-016 Read (ce=1, we=0): rdata SHALL show the addressed word exactly 1 cycle after the request edge; one-cycle latency, no stall or handshake.
- REQ-017 rdata SHALL hold its last value in every cycle following a non-read cycle (ce=0, or a write).
- REQ-018 Write (ce=1, we=1): the full word SHALL commit at the request edge; a read of the same address in the next cycle returns the new data.
- REQ-019 Confreg offsets (addr[15:0]): 0x0000 LED RW, low 16 bits; 0x0004 SWITCH RO, zero-extended switch_in sampled at the request edge; 0x0008 NUM RW, 32 bits; 0x000C TIMER RW; 0x0010 SIMU RO, returns SIMU_FLAG.
- REQ-020 Unmapped confreg offsets SHALL read 0; writes to them and to RO registers SHALL be ignored.
- REQ-021 TIMER SHALL be a free-running 32-bit up-counter, +1 every cycle, wrapping 0xFFFF_FFFF -> 0.
- REQ-022 A TIMER write of V SHALL make TIMER equal V on the next cycle; counting resumes from V after that.
- REQ-023 A TIMER read SHALL return the counter value at the request edge.
- REQ-024 Requests in a cycle where resetn=0 SHALL be ignored; no write occurs and rdata is not updated by them.

Reset
- REQ-025 When resetn=0 at an edge: rdata=0, led_out=16'h0000, num_out=0, TIMER=0.
- REQ-026 Reset SHALL NOT clear RAM contents.
- REQ-027 Reset asserted mid-sequence SHALL take priority over any simultaneous write or TIMER load.

Structure
- REQ-028 A shared package SHALL hold the confreg offset constants (LED, SWITCH, NUM, TIMER, SIMU) and the default CONFREG_HI.
- REQ-029 The RAM array SHALL be a sub-module data_spram: single port, synchronous write, registered read, with parameter AW.
- REQ-030 The confreg registers, TIMER, decode and the rdata output mux SHALL live in data_sram_responder.

Verification
- REQ-031 Write 0x1234_5678 to 0x0000_0040; next cycle read 0x0000_0040 -> rdata=0x1234_5678 one cycle later; rdata holds while ce=0.
- REQ-032 RAM_AW=12: write 0xA5A5_A5A5 to 0x0000_4000; read 0x0000_0000 -> 0xA5A5_A5A5 (wrap); read 0x0000_0003 returns the same word as 0x0000_0000.
- REQ-033 Write 0xDEAD_BEEF to 0xBFAF_0000 -> led_out=0xBEEF; write 0xCAFEBABE to 0xBFAF_0008 -> num_out=0xCAFE_BABE; read 0xBFAF_0020 -> 0.
- REQ-034 Write 0xFFFF_FFFE to TIMER; read TIMER 2 cycles after the write edge -> 0xFFFF_FFFF; read it the following cycle -> 0x0000_0000.
- REQ-035 switch_in=16'h00F0, read 0xBFAF_0004 -> 0x0000_00F0; write to 0xBFAF_0004 -> no effect; read 0xBFAF_0010 -> SIMU_FLAG.
- REQ-036 Drive resetn=0 together with a write to 0x40: -> RAM[0x40] unchanged, rdata=0, led_out=0, TIMER=0; previously written RAM data still readable after reset.
